// File: rtl/jt6295_rom_arb_pkg.sv
// jt6295_rom_arb_pkg
//   Shared definitions for the JT6295 sample-ROM arbiter: requester slot
//   count, the header slot index and the fetch FSM state encoding.
//   Slot 0 is the phrase-table (header) reader, slots 1..4 are ADPCM
//   channels 0..3.
package jt6295_rom_arb_pkg;

    localparam int NSLOTS   = 5;
    localparam int HDR_SLOT = 0;

    // IDLE picks a winner, ISSUE lets the ROM see the new address for one
    // cycle, WAIT holds until the ROM reports valid data.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/jt6295_rr4.sv
// jt6295_rr4
//   Combinational 4-way round-robin picker. The search starts at the
//   pointer and wraps modulo 4, so the first requester at or after rr wins.
//   Ports:
//     req  in  4  request vector, bit i = channel i
//     rr   in  2  round-robin start position
//     any  out 1  at least one request present
//     win  out 2  index of the winning request (0 when none)
module jt6295_rr4 (
    input  logic [3:0] req,
    input  logic [1:0] rr,
    output logic       any,
    output logic [1:0] win
);

    logic [1:0] idx;
    logic       found;

    assign any = |req;

    // Walk rr, rr+1, rr+2, rr+3 with natural 2-bit wrap; first hit wins.
    always_comb begin
        win   = 2'd0;
        found = 1'b0;
        idx   = rr;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jt6295_rom_arb.sv
// jt6295_rom_arb
//   Shares the single JT6295 sample ROM port between the header (phrase
//   table) reader and the four ADPCM channel fetchers. Each requester has a
//   level-style cs/addr/data/ok port backed by a one-byte cache slot; the
//   arbiter serialises misses onto the external ROM port.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     hdr_cs/hdr_addr  header request and byte address (HW bits)
//     hdr_data/hdr_ok  cached header byte and its validity for hdr_addr
//     ch_cs/ch_addr    per-channel requests, packed addresses (ch0 in LSBs)
//     ch_data/ch_ok    packed per-channel bytes and validity flags
//     rom_addr/rom_cs  external ROM address and select
//     rom_data/rom_ok  external ROM read data and valid
module jt6295_rom_arb
    import jt6295_rom_arb_pkg::*;
#(
    parameter int HW = 10,
    parameter int AW = 18
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hdr_cs,
    input  logic [HW-1:0]   hdr_addr,
    output logic [7:0]      hdr_data,
    output logic            hdr_ok,
    input  logic [3:0]      ch_cs,
    input  logic [4*AW-1:0] ch_addr,
    output logic [4*8-1:0]  ch_data,
    output logic [3:0]      ch_ok,
    output logic [AW-1:0]   rom_addr,
    output logic            rom_cs,
    input  logic [7:0]      rom_data,
    input  logic            rom_ok
);

    arb_state_t        state;
    logic [2:0]        gnt;
    logic [1:0]        rr;
    logic [NSLOTS-1:0] valid;
    logic [AW-1:0]     lat_addr [NSLOTS];
    logic [7:0]        lat_data [NSLOTS];

    logic [NSLOTS-1:0] cs_vec;
    logic [AW-1:0]     req_addr [NSLOTS];
    logic [NSLOTS-1:0] ok_vec;
    logic [NSLOTS-1:0] pending;
    logic              ch_any;
    logic [1:0]        ch_win;
    logic              grant;
    logic [2:0]        win_slot;

    // Flatten both requester kinds into slot-indexed vectors; the header
    // address is zero-extended onto the ROM address space.
    always_comb begin
        cs_vec = {ch_cs, hdr_cs};
        req_addr[HDR_SLOT] = {{(AW-HW){1'b0}}, hdr_addr};
        for (int i = 0; i < 4; i++) begin
            req_addr[i+1] = ch_addr[i*AW +: AW];
        end
    end

    // A slot hits when its cached byte is valid for the address currently
    // asked for. Misses become pending, except the slot already in flight,
    // which must not be granted twice.
    always_comb begin
        ok_vec  = '0;
        pending = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            ok_vec[i]  = cs_vec[i] && valid[i] && (req_addr[i] == lat_addr[i]);
            pending[i] = cs_vec[i] && !ok_vec[i]
                         && !((state != ST_IDLE) && (gnt == 3'(i)));
        end
    end

    // Data ports always show the cached byte; ok tells whether it applies.
    always_comb begin
        ch_data = '0;
        for (int i = 0; i < 4; i++) begin
            ch_data[i*8 +: 8] = lat_data[i+1];
        end
    end

    assign hdr_data = lat_data[HDR_SLOT];
    assign hdr_ok   = ok_vec[HDR_SLOT];
    assign ch_ok    = ok_vec[4:1];

    jt6295_rr4 u_rr4 (
        .req (pending[4:1]),
        .rr  (rr),
        .any (ch_any),
        .win (ch_win)
    );

    // Header beats every channel; otherwise the round-robin winner, offset
    // by one because channel slots start at 1.
    always_comb begin
        grant    = pending[HDR_SLOT] || ch_any;
        win_slot = pending[HDR_SLOT] ? 3'(HDR_SLOT) : ({1'b0, ch_win} + 3'd1);
    end

    // Fetch FSM. The granted slot is invalidated and its address latched at
    // grant time, so an address change during the fetch leaves a mismatch
    // and the slot simply re-requests afterwards. rom_addr holds from grant
    // until capture; rom_ok during ISSUE is ignored as possibly stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= 3'd0;
            rr       <= 2'd0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            valid    <= '0;
            for (int i = 0; i < NSLOTS; i++) begin
                lat_addr[i] <= '0;
                lat_data[i] <= 8'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt                <= win_slot;
                        rom_addr           <= req_addr[win_slot];
                        lat_addr[win_slot] <= req_addr[win_slot];
                        valid[win_slot]    <= 1'b0;
                        rom_cs             <= 1'b1;
                        state              <= ST_ISSUE;
                        if (!pending[HDR_SLOT]) begin
                            rr <= ch_win + 2'd1;
                        end
                    end else begin
                        rom_cs <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rom_ok) begin
                        lat_data[gnt] <= rom_data;
                        valid[gnt]    <= 1'b1;
                        rom_cs        <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    rom_cs <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jt6295_rom_arb.sv
// tb_jt6295_rom_arb
//   Directed bench for the JT6295 ROM arbiter. A small ROM model answers
//   with data derived from the address after a programmable latency, and
//   can be forced to assert a stale rom_ok.
module tb_jt6295_rom_arb;

    localparam int HW = 10;
    localparam int AW = 18;

    logic            clk;
    logic            rst_n;
    logic            hdr_cs;
    logic [HW-1:0]   hdr_addr;
    logic [7:0]      hdr_data;
    logic            hdr_ok;
    logic [3:0]      ch_cs;
    logic [4*AW-1:0] ch_addr;
    logic [4*8-1:0]  ch_data;
    logic [3:0]      ch_ok;
    logic [AW-1:0]   rom_addr;
    logic            rom_cs;
    logic [7:0]      rom_data;
    logic            rom_ok;

    int n_checks;
    int n_fail;

    int   rom_lat;
    int   rom_cnt;
    logic rom_ok_force;

    jt6295_rom_arb #(.HW(HW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hdr_cs   (hdr_cs),
        .hdr_addr (hdr_addr),
        .hdr_data (hdr_data),
        .hdr_ok   (hdr_ok),
        .ch_cs    (ch_cs),
        .ch_addr  (ch_addr),
        .ch_data  (ch_data),
        .ch_ok    (ch_ok),
        .rom_addr (rom_addr),
        .rom_cs   (rom_cs),
        .rom_data (rom_data),
        .rom_ok   (rom_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a fixed scramble of the address.
    function automatic logic [7:0] romf(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA0 ^ {a[17:16], 6'b0};
    endfunction

    // Count cycles rom_cs has been high; data becomes valid after rom_lat.
    always @(posedge clk) begin
        if (!rom_cs) rom_cnt <= 0;
        else         rom_cnt <= rom_cnt + 1;
    end

    assign rom_data = romf(rom_addr);
    assign rom_ok   = rom_ok_force || (rom_cs && (rom_cnt >= rom_lat));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic [AW-1:0] a);
        ch_addr[i*AW +: AW] = a;
    endtask

    // From an IDLE cycle with a pending request: one fetch at immediate ROM
    // latency, checking the grant address, the gap cycle and the result.
    task automatic expect_fetch(input string tag, input logic [AW-1:0] exp_addr,
                                input int slot);
        logic [7:0] d;
        logic       o;
        step(1);
        checkOutput({tag, "_rom_cs"}, 32'(rom_cs), 32'd1);
        checkOutput({tag, "_rom_addr"}, 32'(rom_addr), 32'(exp_addr));
        step(2);
        checkOutput({tag, "_gap_cs"}, 32'(rom_cs), 32'd0);
        if (slot == 0) begin
            o = hdr_ok;
            d = hdr_data;
        end else begin
            o = ch_ok[slot-1];
            d = ch_data[(slot-1)*8 +: 8];
        end
        checkOutput({tag, "_ok"}, 32'(o), 32'd1);
        checkOutput({tag, "_data"}, 32'(d), 32'(romf(exp_addr)));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rom_lat      = 0;
        rom_cnt      = 0;
        rom_ok_force = 1'b0;
        rst_n        = 1'b0;
        hdr_cs       = 1'b0;
        hdr_addr     = '0;
        ch_cs        = 4'd0;
        ch_addr      = '0;

        // Reset state.
        step(2);
        checkOutput("rst_rom_cs", 32'(rom_cs), 32'd0);
        checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
        checkOutput("rst_ok", {27'd0, ch_ok, hdr_ok}, 32'd0);
        checkOutput("rst_data", ch_data, 32'd0);
        checkOutput("rst_hdr_data", 32'(hdr_data), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single header read with cycle-accurate latency.
        $display("[TB] single header read");
        hdr_cs   = 1'b1;
        hdr_addr = 10'h005;
        step(1);
        checkOutput("hdr_rom_cs", 32'(rom_cs), 32'd1);
        checkOutput("hdr_rom_addr", 32'(rom_addr), 32'h00005);
        step(1);
        checkOutput("hdr_ok_c2", 32'(hdr_ok), 32'd0);
        step(1);
        checkOutput("hdr_ok_c3", 32'(hdr_ok), 32'd1);
        checkOutput("hdr_data_c3", 32'(hdr_data), 32'hA5);
        step(2);
        checkOutput("hdr_no_refetch", 32'(rom_cs), 32'd0);
        hdr_cs = 1'b0;
        step(1);
        checkOutput("hdr_ok_cs_low", 32'(hdr_ok), 32'd0);
        hdr_cs = 1'b1;
        step(1);
        checkOutput("hdr_ok_reassert", 32'(hdr_ok), 32'd1);
        checkOutput("hdr_reassert_no_rom", 32'(rom_cs), 32'd0);

        // Contention: header first, then channels 0..3, 3 cycles apart.
        $display("[TB] contention");
        hdr_addr = 10'h010;
        set_ch(0, 18'h00100);
        set_ch(1, 18'h00201);
        set_ch(2, 18'h00302);
        set_ch(3, 18'h00403);
        ch_cs = 4'hF;
        expect_fetch("cont_hdr", 18'h00010, 0);
        expect_fetch("cont_ch0", 18'h00100, 1);
        expect_fetch("cont_ch1", 18'h00201, 2);
        expect_fetch("cont_ch2", 18'h00302, 3);
        expect_fetch("cont_ch3", 18'h00403, 4);
        checkOutput("cont_all_ok", {27'd0, ch_ok, hdr_ok}, 32'h1F);
        checkOutput("cont_ch_data", ch_data, 32'hA7A1A3A1);

        // Fairness: ch0 and ch2 keep moving; grants alternate.
        $display("[TB] round-robin fairness");
        hdr_cs = 1'b0;
        ch_cs  = 4'b0101;
        set_ch(0, 18'h00110);
        set_ch(2, 18'h00312);
        expect_fetch("rr_g0_ch0", 18'h00110, 1);
        set_ch(0, 18'h00111);
        expect_fetch("rr_g1_ch2", 18'h00312, 3);
        set_ch(2, 18'h00313);
        expect_fetch("rr_g2_ch0", 18'h00111, 1);
        expect_fetch("rr_g3_ch2", 18'h00313, 3);
        step(1);
        checkOutput("rr_settled", 32'(rom_cs), 32'd0);

        // Address change while ch1 is in flight.
        $display("[TB] address change in flight");
        set_ch(1, 18'h01000);
        ch_cs = 4'b0111;
        step(1);
        checkOutput("chg_rom_addr1", 32'(rom_addr), 32'h01000);
        step(1);
        set_ch(1, 18'h01001);
        step(1);
        checkOutput("chg_ok_after_first", 32'(ch_ok[1]), 32'd0);
        checkOutput("chg_gap_cs", 32'(rom_cs), 32'd0);
        step(1);
        checkOutput("chg_refetch_cs", 32'(rom_cs), 32'd1);
        checkOutput("chg_refetch_addr", 32'(rom_addr), 32'h01001);
        checkOutput("chg_ok_refetch", 32'(ch_ok[1]), 32'd0);
        step(2);
        checkOutput("chg_ok_final", 32'(ch_ok[1]), 32'd1);
        checkOutput("chg_data_final", 32'(ch_data[15:8]), 32'hB1);

        // Slow ROM with a stale rom_ok during ISSUE.
        $display("[TB] slow rom");
        rom_lat = 5;
        set_ch(3, 18'h00404);
        ch_cs = 4'hF;
        step(1);
        checkOutput("slow_rom_addr", 32'(rom_addr), 32'h00404);
        rom_ok_force = 1'b1;
        step(1);
        rom_ok_force = 1'b0;
        checkOutput("slow_no_issue_capture", 32'(ch_ok[3]), 32'd0);
        step(4);
        checkOutput("slow_ok_c6", 32'(ch_ok[3]), 32'd0);
        checkOutput("slow_cs_c6", 32'(rom_cs), 32'd1);
        checkOutput("slow_addr_stable", 32'(rom_addr), 32'h00404);
        step(1);
        checkOutput("slow_ok_c7", 32'(ch_ok[3]), 32'd1);
        checkOutput("slow_data_c7", 32'(ch_data[31:24]), 32'hA0);

        // Reset pulse while a header fetch waits on the slow ROM.
        $display("[TB] reset mid-fetch");
        hdr_cs   = 1'b1;
        hdr_addr = 10'h3FF;
        step(1);
        checkOutput("rstm_rom_addr", 32'(rom_addr), 32'h003FF);
        step(1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstm_cs_async", 32'(rom_cs), 32'd0);
        checkOutput("rstm_ok_all", {27'd0, ch_ok, hdr_ok}, 32'd0);
        checkOutput("rstm_rom_addr0", 32'(rom_addr), 32'd0);
        step(1);
        rst_n   = 1'b1;
        rom_lat = 0;
        expect_fetch("rstm_refetch", 18'h003FF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
